// File: rtl/dru_ctrl_if.sv
// Signal bundle between the DRU sequencing controller and its status/receive-path neighbours.
// master = controller side; slave = the side that drives requests and observes the DRU controls.
interface dru_ctrl_if;
    // No valid/ready here: i_restart is a one-cycle pulse (or a held level) sampled on the clock edge.
    // i_al_ppm is a level. All o_* signals are registered levels that stay valid until the controller changes them.
    logic       i_restart;
    logic       i_al_ppm;
    logic       o_dru_rst;
    logic       o_dru_rst_freq;
    logic       o_dru_en;
    logic [4:0] o_g1;
    logic [4:0] o_g1_p;
    logic [4:0] o_g2;
    logic       o_locked;
    logic [7:0] o_relock_cnt;
    logic [2:0] o_state;

    modport master (
        input  i_restart, i_al_ppm,
        output o_dru_rst, o_dru_rst_freq, o_dru_en, o_g1, o_g1_p, o_g2,
               o_locked, o_relock_cnt, o_state
    );

    modport slave (
        output i_restart, i_al_ppm,
        input  o_dru_rst, o_dru_rst_freq, o_dru_en, o_g1, o_g1_p, o_g2,
               o_locked, o_relock_cnt, o_state
    );
endinterface

// File: rtl/dru_ctrl.sv
// Start-up, gain-switching, lock detection and PPM-alarm recovery sequencer for the DRU.
// Every output comes straight from a flop; o_state exposes the FSM for status and checkers.
module dru_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned FREQ_CYCLES  = 64,
    parameter int unsigned ACQ_CYCLES   = 4096,
    parameter int unsigned LOCK_CYCLES  = 65536,
    parameter int unsigned ALARM_CYCLES = 256,
    parameter logic [4:0]  G1_ACQ       = 5'd4,
    parameter logic [4:0]  G1P_ACQ      = 5'd2,
    parameter logic [4:0]  G2_ACQ       = 5'd4,
    parameter logic [4:0]  G1_TRK       = 5'd8,
    parameter logic [4:0]  G1P_TRK      = 5'd6,
    parameter logic [4:0]  G2_TRK       = 5'd10
) (
    input  logic         i_clk,
    input  logic         i_nrst,
    dru_ctrl_if.master   bus
);

    localparam logic [2:0] ST_RESET     = 3'd0;
    localparam logic [2:0] ST_FREQ_HOLD = 3'd1;
    localparam logic [2:0] ST_ACQ       = 3'd2;
    localparam logic [2:0] ST_TRACK     = 3'd3;
    localparam logic [2:0] ST_LOCKED    = 3'd4;

    localparam logic [23:0] RST_LAST   = 24'(RST_CYCLES - 1);
    localparam logic [23:0] FREQ_LAST  = 24'(FREQ_CYCLES - 1);
    localparam logic [23:0] ACQ_LAST   = 24'(ACQ_CYCLES - 1);
    localparam logic [23:0] LOCK_LAST  = 24'(LOCK_CYCLES - 1);
    localparam logic [23:0] ALARM_LAST = 24'(ALARM_CYCLES - 1);

    logic [2:0]  state_q,    state_d;
    logic [23:0] cnt_q,      cnt_d;
    logic        rst_q,      rst_d;
    logic        rst_freq_q, rst_freq_d;
    logic        en_q,       en_d;
    logic [4:0]  g1_q,       g1_d;
    logic [4:0]  g1_p_q,     g1_p_d;
    logic [4:0]  g2_q,       g2_d;
    logic        locked_q,   locked_d;
    logic [7:0]  relock_q,   relock_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rst_d      = rst_q;
        rst_freq_d = rst_freq_q;
        en_d       = en_q;
        g1_d       = g1_q;
        g1_p_d     = g1_p_q;
        g2_d       = g2_q;
        locked_d   = locked_q;
        relock_d   = relock_q;

        if (bus.i_restart) begin
            // Restart wins over everything but keeps the recovery history.
            state_d    = ST_RESET;
            cnt_d      = '0;
            rst_d      = 1'b1;
            rst_freq_d = 1'b1;
            en_d       = 1'b0;
            locked_d   = 1'b0;
            g1_d       = G1_ACQ;
            g1_p_d     = G1P_ACQ;
            g2_d       = G2_ACQ;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_FREQ_HOLD;
                        cnt_d   = '0;
                        rst_d   = 1'b0;
                        en_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                ST_FREQ_HOLD: begin
                    rst_freq_d = 1'b1;
                    g1_d       = G1_ACQ;
                    g1_p_d     = G1P_ACQ;
                    g2_d       = G2_ACQ;
                    if (cnt_q == FREQ_LAST) begin
                        state_d    = ST_ACQ;
                        cnt_d      = '0;
                        rst_freq_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                ST_ACQ: begin
                    if (cnt_q == ACQ_LAST) begin
                        state_d = ST_TRACK;
                        cnt_d   = '0;
                        g1_d    = G1_TRK;
                        g1_p_d  = G1P_TRK;
                        g2_d    = G2_TRK;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                ST_TRACK: begin
                    // cnt holds the run length of alarm-free cycles.
                    if (bus.i_al_ppm) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d  = ST_LOCKED;
                        cnt_d    = '0;
                        locked_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                ST_LOCKED: begin
                    // cnt holds the run length of alarmed cycles.
                    if (!bus.i_al_ppm) begin
                        cnt_d = '0;
                    end else if (cnt_q == ALARM_LAST) begin
                        state_d    = ST_FREQ_HOLD;
                        cnt_d      = '0;
                        locked_d   = 1'b0;
                        rst_freq_d = 1'b1;
                        g1_d       = G1_ACQ;
                        g1_p_d     = G1P_ACQ;
                        g2_d       = G2_ACQ;
                        if (relock_q != 8'hFF) begin
                            relock_d = relock_q + 8'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_d    = ST_RESET;
                    cnt_d      = '0;
                    rst_d      = 1'b1;
                    rst_freq_d = 1'b1;
                    en_d       = 1'b0;
                    locked_d   = 1'b0;
                    g1_d       = G1_ACQ;
                    g1_p_d     = G1P_ACQ;
                    g2_d       = G2_ACQ;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            rst_q      <= 1'b1;
            rst_freq_q <= 1'b1;
            en_q       <= 1'b0;
            g1_q       <= G1_ACQ;
            g1_p_q     <= G1P_ACQ;
            g2_q       <= G2_ACQ;
            locked_q   <= 1'b0;
            relock_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_q      <= rst_d;
            rst_freq_q <= rst_freq_d;
            en_q       <= en_d;
            g1_q       <= g1_d;
            g1_p_q     <= g1_p_d;
            g2_q       <= g2_d;
            locked_q   <= locked_d;
            relock_q   <= relock_d;
        end
    end

    assign bus.o_dru_rst      = rst_q;
    assign bus.o_dru_rst_freq = rst_freq_q;
    assign bus.o_dru_en       = en_q;
    assign bus.o_g1           = g1_q;
    assign bus.o_g1_p         = g1_p_q;
    assign bus.o_g2           = g2_q;
    assign bus.o_locked       = locked_q;
    assign bus.o_relock_cnt   = relock_q;
    assign bus.o_state        = state_q;

endmodule

// File: tb/tb_dru_ctrl.sv
// Directed bench for dru_ctrl with short phase lengths; expected outputs come from a
// phase timeline (durations 4/3/8/16, alarm window 5) built from the block's behaviour.
module tb_dru_ctrl;
    localparam int RST_C   = 4;
    localparam int FREQ_C  = 3;
    localparam int ACQ_C   = 8;
    localparam int LOCK_C  = 16;
    localparam int ALARM_C = 5;

    logic clk;
    logic nrst;
    int   n_checks;
    int   n_errors;
    int   exp_relock;

    dru_ctrl_if bus ();

    dru_ctrl #(
        .RST_CYCLES   (RST_C),
        .FREQ_CYCLES  (FREQ_C),
        .ACQ_CYCLES   (ACQ_C),
        .LOCK_CYCLES  (LOCK_C),
        .ALARM_CYCLES (ALARM_C)
    ) dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .bus    (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for a given phase: 0 RESET, 1 FREQ_HOLD, 2 ACQ, 3 TRACK, 4 LOCKED.
    task automatic check_outs(input string tag, input int ph);
        check({tag, ".state"},    32'(bus.o_state), 32'(ph));
        check({tag, ".rst"},      32'(bus.o_dru_rst), 32'(ph == 0));
        check({tag, ".rst_freq"}, 32'(bus.o_dru_rst_freq), 32'(ph <= 1));
        check({tag, ".en"},       32'(bus.o_dru_en), 32'(ph != 0));
        check({tag, ".gains"},    32'({bus.o_g1, bus.o_g1_p, bus.o_g2}),
              (ph >= 3) ? 32'({5'd8, 5'd6, 5'd10}) : 32'({5'd4, 5'd2, 5'd4}));
        check({tag, ".locked"},   32'(bus.o_locked), 32'(ph == 4));
        check({tag, ".relock"},   32'(bus.o_relock_cnt), 32'(exp_relock));
    endtask

    // Walks from a freshly entered phase to LOCKED, checking every edge.
    // glitch_r > 0 pulses i_al_ppm for the edge with that relative number (must fall in TRACK).
    task automatic run_timeline(input string tag, input int start_ph, input int glitch_r);
        int dur [4];
        int ph;
        int cnt;
        int r;
        dur = '{RST_C, FREQ_C, ACQ_C, LOCK_C};
        ph  = start_ph;
        cnt = 0;
        r   = 0;
        while (ph != 4 && r < 200) begin
            r++;
            bus.i_al_ppm = (r == glitch_r);
            tick();
            bus.i_al_ppm = 1'b0;
            if (ph == 3 && r == glitch_r) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == dur[ph]) begin
                    ph++;
                    cnt = 0;
                end
            end
            check_outs($sformatf("%s.e%0d", tag, r), ph);
        end
        check({tag, ".reached_lock"}, 32'(bus.o_state), 32'd4);
    endtask

    task automatic alarm_burst(input int n);
        bus.i_al_ppm = 1'b1;
        repeat (n) tick();
        bus.i_al_ppm = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_relock = 0;
        nrst          = 1'b0;
        bus.i_restart = 1'b0;
        bus.i_al_ppm  = 1'b0;
        repeat (3) tick();
        check_outs("reset", 0);

        // Start-up: rst falls after edge 4, rst_freq after 7, gains after 15, lock after 31.
        nrst = 1'b1;
        run_timeline("startup", 0, 0);

        // Glitch in TRACK at edge 25 pushes lock out to edge 41.
        #1 nrst = 1'b0;
        #1 check_outs("reset2", 0);
        repeat (2) tick();
        nrst = 1'b1;
        run_timeline("glitch", 0, 25);

        // Alarm runs of 4 do nothing; a run of 5 triggers recovery.
        alarm_burst(ALARM_C - 1);
        check_outs("alarm4", 4);
        tick();
        check_outs("alarm4_clear", 4);
        alarm_burst(ALARM_C - 1);
        check_outs("alarm4b", 4);
        bus.i_al_ppm = 1'b1;
        tick();
        bus.i_al_ppm = 1'b0;
        exp_relock = 1;
        check_outs("recover", 1);
        run_timeline("relock", 1, 0);

        // Saturation: 299 more recoveries, count must hold at 255.
        for (int i = 0; i < 299; i++) begin
            alarm_burst(ALARM_C);
            if (exp_relock < 255) exp_relock++;
            check("sat.relock", 32'(bus.o_relock_cnt), 32'(exp_relock));
            check("sat.state",  32'(bus.o_state), 32'd1);
            repeat (FREQ_C + ACQ_C + LOCK_C) tick();
            check("sat.locked", 32'(bus.o_locked), 32'd1);
        end
        check_outs("sat_final", 4);

        // One-cycle restart from LOCKED.
        bus.i_restart = 1'b1;
        tick();
        bus.i_restart = 1'b0;
        check_outs("restart1", 0);
        run_timeline("restart1", 0, 0);

        // Restart held for 10 cycles keeps the FSM parked in RESET.
        bus.i_restart = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_outs("restart_hold", 0);
        end
        bus.i_restart = 1'b0;
        run_timeline("restart_held", 0, 0);

        // Async reset mid-ACQ, outputs must change before any clock edge.
        bus.i_restart = 1'b1;
        tick();
        bus.i_restart = 1'b0;
        repeat (RST_C + FREQ_C + 2) tick();
        check_outs("mid_acq", 2);
        #1 nrst = 1'b0;
        exp_relock = 0;
        #1 check_outs("async_rst", 0);
        repeat (2) tick();
        nrst = 1'b1;
        run_timeline("startup2", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dru_ctrl.md
Name: dru_ctrl

Overview:
Sequencing controller for the technology-wrapped data recovery unit (dru_tech). It drives the DRU's reset, frequency-reset and enable inputs through a start-up sequence. It switches the loop gains from acquisition to tracking values and declares lock. It watches the DRU PPM alarm (AL_PPM) and re-runs frequency acquisition when the loop drifts. It sits between the system reset/CSR logic and the DRU instance in the receive path.

Parameters:
RST_CYCLES, 16, cycles o_dru_rst stays high after reset release or restart (1..2^24-1)
FREQ_CYCLES, 64, cycles o_dru_rst_freq stays high per frequency acquisition (1..2^24-1)
ACQ_CYCLES, 4096, cycles with acquisition gains before switching to tracking gains (1..2^24-1)
LOCK_CYCLES, 65536, consecutive alarm-free tracking cycles needed to declare lock (1..2^24-1)
ALARM_CYCLES, 256, consecutive i_al_ppm cycles in LOCKED that trigger recovery (1..2^24-1)
G1_ACQ, 5'd4 / G1P_ACQ, 5'd2 / G2_ACQ, 5'd4, acquisition gains
G1_TRK, 5'd8 / G1P_TRK, 5'd6 / G2_TRK, 5'd10, tracking gains

Ports:
i_clk  in  1  single clock, same clock as DRU CLK
i_nrst  in  1  asynchronous active-low reset
i_restart  in  1  single-cycle request for a full DRU re-initialisation
i_al_ppm  in  1  DRU AL_PPM output
o_dru_rst  out  1  to DRU RST
o_dru_rst_freq  out  1  to DRU RST_FREQ
o_dru_en  out  1  to DRU EN
o_g1  out  5  to DRU G1
o_g1_p  out  5  to DRU G1_P
o_g2  out  5  to DRU G2
o_locked  out  1  loop locked indication
o_relock_cnt  out  8  count of alarm-driven recoveries, saturating
o_state  out  3  current FSM state code, for status CSR

Behaviour:
- All outputs are registered. There is no combinational path from inputs to outputs.
- Async reset values: state=RESET(0), cnt=0, o_dru_rst=1, o_dru_rst_freq=1, o_dru_en=0, gains=ACQ values, o_locked=0, o_relock_cnt=0.
- FSM state codes: RESET=0, FREQ_HOLD=1, ACQ=2, TRACK=3, LOCKED=4.
- RESET: cnt increments each cycle. On the edge where cnt==RST_CYCLES-1:
  - state goes to FREQ_HOLD, cnt=0;
  - o_dru_rst=0, o_dru_en=1.
  - o_dru_rst is therefore high for exactly RST_CYCLES edges after release.
- FREQ_HOLD: o_dru_rst_freq=1 and gains=ACQ. On the edge where cnt==FREQ_CYCLES-1: state goes to ACQ, cnt=0, o_dru_rst_freq=0.
- ACQ: on the edge where cnt==ACQ_CYCLES-1: state goes to TRACK, cnt=0, gains are loaded with TRK values on the same edge.
- TRACK: counts consecutive cycles with i_al_ppm==0. i_al_ppm==1 clears cnt to 0 (no state change). On the edge where cnt==LOCK_CYCLES-1 with i_al_ppm==0: state goes to LOCKED, cnt=0, o_locked=1.
- LOCKED: counts consecutive cycles with i_al_ppm==1. i_al_ppm==0 clears cnt. On the edge where cnt==ALARM_CYCLES-1 with i_al_ppm==1:
  - state goes to FREQ_HOLD, cnt=0;
  - o_locked=0, o_dru_rst_freq=1, gains=ACQ;
  - o_relock_cnt increments, holding at 255 once saturated.
- i_restart=1 has highest priority in any state:
  - next state RESET, cnt=0;
  - o_dru_rst=1, o_dru_rst_freq=1, o_dru_en=0, o_locked=0, gains=ACQ.
  - o_relock_cnt is not cleared.
  - i_restart held high keeps the FSM in RESET with cnt=0. Counting starts on the first edge after it drops.
- o_dru_en stays 1 in every state except RESET.
- cnt is 24 bits and never wraps, because each state exits at its terminal count.
- Async reset mid-operation returns immediately to the reset values above.

Test Plan:
(All with RST_CYCLES=4, FREQ_CYCLES=3, ACQ_CYCLES=8, LOCK_CYCLES=16, ALARM_CYCLES=5, i_al_ppm=0. Edges are counted after i_nrst rises.)
- Start-up: o_dru_rst falls and o_dru_en rises after edge 4; o_dru_rst_freq falls after edge 7; gains change 4/2/4 -> 8/6/10 after edge 15; o_locked rises after edge 31; o_state reads 0,1,2,3,4 in order.
- Alarm glitch in TRACK: i_al_ppm=1 for one cycle at edge 25 -> lock-free count restarts, o_locked rises after edge 41.
- Alarm recovery: in LOCKED, i_al_ppm=1 for 4 cycles then 0 -> no change. i_al_ppm=1 for 5 cycles -> o_locked=0, o_dru_rst_freq=1 for 3 cycles, o_relock_cnt=1, gains return to ACQ, lock reasserts 3+8+16 edges later.
- Saturation: force 300 recoveries -> o_relock_cnt stays at 255.
- Restart in LOCKED: 1-cycle i_restart -> o_dru_rst=1 for 4 edges, o_dru_en=0, o_relock_cnt unchanged. Restart held 10 cycles -> o_dru_rst falls 4 edges after release.
- Async reset asserted mid-ACQ -> all outputs at reset values without waiting for a clock edge; the start-up timeline repeats exactly after release.
